fetch_unit: RTL and testbench

Instruction-fetch requester for the pipelined core. It owns the PC and drives the instruction-memory read port (iREN/imemaddr), consuming imemload/ihit from the cache or the stub memory. Fetched words are presented to the IF/ID stage through a valid/stall handshake. The unit has a one-entry skid buffer, branch/jump redirect, and halt-word detection.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the PC, issues reads to instruction memory
// and hands fetched words to IF/ID through a valid/stall handshake with a one-word skid buffer.
module fetch_unit #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // state | meaning
  // FETCH | reading memory at PC, words go to the output or the skid buffer
  // HOLD  | skid buffer full, waiting for downstream to take it
  // HALT  | halt word fetched, PC frozen until redirect or reset
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] count_q, count_d;
  logic        ready;
  logic        is_halt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      buf_q    <= 32'h0;
      buf_pc_q <= 32'h0;
      count_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      buf_q    <= buf_d;
      buf_pc_q <= buf_pc_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    buf_d    = buf_q;
    buf_pc_d = buf_pc_q;
    count_d  = count_q;
    iREN     = 1'b0;
    ready    = !stall || !valid_q;
    is_halt  = (imemload == HALT_WORD);

    case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          count_d = count_q + 32'd1;
          // The halt word is delivered but the PC stays on it
          if (!is_halt) pc_d = pc_q + 32'd4;
          if (ready) begin
            instr_d  = imemload;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = is_halt ? HALT : FETCH;
          end else begin
            buf_d    = imemload;
            buf_pc_d = pc_q;
            state_d  = HOLD;
          end
        end else if (ready) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (ready) begin
          instr_d  = buf_q;
          pc_out_d = buf_pc_q;
          valid_d  = 1'b1;
          state_d  = (buf_q == HALT_WORD) ? HALT : FETCH;
        end
      end
      HALT: begin
        if (ready) valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase

    // A redirect discards anything fetched this cycle, including a same-cycle hit
    if (redirect_en) begin
      state_d  = FETCH;
      pc_d     = {redirect_pc[31:2], 2'b00};
      valid_d  = 1'b0;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      buf_d    = 32'h0;
      buf_pc_d = 32'h0;
      count_d  = count_q;
    end
  end

  assign imemaddr    = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign npc_out     = pc_out_q + 32'd4;
  assign halted      = (state_q == HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_out(instr_out),
    .pc_out(pc_out), .npc_out(npc_out), .halted(halted), .fetch_count(fetch_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: program counter, delivered word, pending words awaiting delivery
  logic [31:0] m_pc, m_instr, m_opc, m_cnt;
  logic        m_valid, m_halted;
  logic [63:0] m_pend[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    case (a)
      32'h0:  return 32'h3401_D269;
      32'h4:  return 32'h3402_37F1;
      32'h8:  return 32'h3415_0080;
      32'h3C: return HALT_W;
      default: begin
        if ((idx % 37) == 36) return HALT_W;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst_b, input logic hit, input logic stl,
                            input logic redir, input logic [31:0] rpc);
    logic        rdy;
    logic [31:0] w;
    logic [63:0] e;
    if (!rst_b) begin
      m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_pend.delete();
    end else if (redir) begin
      m_pc = rpc & ~32'h3; m_valid = 1'b0; m_halted = 1'b0; m_pend.delete();
    end else begin
      rdy = !stl || !m_valid;
      if (m_pend.size() > 0) begin
        if (rdy) begin
          e = m_pend.pop_front();
          m_instr = e[63:32]; m_opc = e[31:0]; m_valid = 1'b1;
          if (m_instr == HALT_W) m_halted = 1'b1;
        end
      end else if (m_halted) begin
        if (rdy) m_valid = 1'b0;
      end else if (hit) begin
        w = mem_word(m_pc);
        m_cnt = m_cnt + 1;
        if (rdy) begin
          m_instr = w; m_opc = m_pc; m_valid = 1'b1;
          if (w == HALT_W) m_halted = 1'b1;
        end else begin
          m_pend.push_back({w, m_pc});
        end
        if (w != HALT_W) m_pc = m_pc + 4;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("iREN",        {31'b0, iREN}, {31'b0, (!m_halted && m_pend.size() == 0)});
    chk("imemaddr",    imemaddr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instr_out",   instr_out, m_instr);
    chk("pc_out",      pc_out, m_opc);
    chk("npc_out",     npc_out, m_opc + 32'd4);
    chk("halted",      {31'b0, halted}, {31'b0, m_halted});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare on the falling edge
  task automatic cycle(input logic rst_b, input logic hit, input logic stl,
                       input logic redir, input logic [31:0] rpc);
    nRST = rst_b; ihit = hit; stall = stl; redirect_en = redir; redirect_pc = rpc;
    imemload = mem_word(m_pc);
    @(posedge CLK);
    model_step(rst_b, hit, stl, redir, rpc);
    @(negedge CLK);
    check_all();
  endtask

  logic [31:0] cnt_snap;

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0;
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    redirect_pc = 32'h0; imemload = 32'h0;

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    chk("rst_iren", {31'b0, iREN}, 32'd1);
    chk("rst_addr", imemaddr, 32'h0);

    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_instr", instr_out, 32'h3401_D269);
    chk("first_pc", pc_out, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("second_instr", instr_out, 32'h3402_37F1);
    chk("second_npc", npc_out, 32'h8);
    chk("second_cnt", fetch_count, 32'd2);

    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("skid_iren", {31'b0, iREN}, 32'd0);
    chk("skid_hold", instr_out, 32'h3402_37F1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_instr", instr_out, 32'h3415_0080);
    chk("drain_pc", pc_out, 32'h8);
    chk("drain_addr", imemaddr, 32'hC);
    chk("drain_iren", {31'b0, iREN}, 32'd1);

    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_instr", instr_out, HALT_W);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_addr", imemaddr, 32'h3C);
    chk("halt_cnt", fetch_count, 32'd16);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_cnt_frozen", fetch_count, 32'd16);
    chk("halt_addr_frozen", imemaddr, 32'h3C);

    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h13);
    chk("redir_addr", imemaddr, 32'h10);
    chk("redir_halted", {31'b0, halted}, 32'd0);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_pc", pc_out, 32'h10);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cnt_snap = m_cnt;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h4);
    chk("redir_hit_cnt", fetch_count, cnt_snap);
    chk("redir_hit_addr", imemaddr, 32'h4);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("bubble_valid", {31'b0, instr_valid}, 32'd0);
      chk("bubble_addr", imemaddr, 32'h4);
    end

    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_iren", {31'b0, iREN}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_addr", imemaddr, 32'h0);
    chk("midrst_instr", instr_out, 32'h0);
    chk("midrst_cnt", fetch_count, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_hit, r_stl, r_red;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 199) != 0);
      r_hit = ($urandom_range(0, 3) != 0);
      r_stl = ($urandom_range(0, 9) < 3);
      r_red = ($urandom_range(0, 39) == 0);
      r_pc  = $urandom_range(0, 32'h3FF);
      cycle(r_rst, r_hit, r_stl, r_red, r_pc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
